// File: rtl/main_mem_ctrl.sv
// Main-memory controller: arbitrates icache/dcache block requests against a fixed-latency block array.
// Optional init/preload write port enabled by defining MAIN_MEM_CTRL_INIT_PORT_EN.
module main_mem_ctrl #(
  parameter int unsigned BLOCK_WIDTH      = 64,
  parameter int unsigned BLOCK_ADDR_WIDTH = 29,
  parameter int unsigned MEM_DEPTH        = 1024,
  parameter int unsigned MEM_LATENCY      = 4
) (
  input  logic                        clk,
  input  logic                        rst_aH,
  input  logic                        icache_flush,
  input  logic                        icache_req_valid,
  input  logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr,
  output logic                        icache_req_ready,
  output logic                        icache_resp_valid,
  output logic [BLOCK_WIDTH-1:0]      icache_resp_block_data,
  input  logic                        dcache_req_valid,
  input  logic                        dcache_req_type,
  input  logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr,
  input  logic [BLOCK_WIDTH-1:0]      dcache_req_block_data,
  output logic                        dcache_req_ready,
  output logic                        dcache_resp_valid,
  output logic [BLOCK_WIDTH-1:0]      dcache_resp_block_data
`ifdef MAIN_MEM_CTRL_INIT_PORT_EN
  ,
  input  logic                        init_we,
  input  logic [BLOCK_ADDR_WIDTH-1:0] init_block_addr,
  input  logic [BLOCK_WIDTH-1:0]      init_block_data
`endif
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [BLOCK_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                        req_type_q, req_type_d;
  logic [BLOCK_WIDTH-1:0]      req_data_q, req_data_d;
  logic                        i_fire, d_fire, mem_we;
  logic                        init_active;
  logic [IDX_W-1:0]            req_idx;

  logic [BLOCK_WIDTH-1:0]      mem [MEM_DEPTH];

  // Upper address bits alias onto the same array entry.
  assign req_idx = req_addr_q[IDX_W-1:0];

  logic unused_req_addr_hi;
  assign unused_req_addr_hi = ^req_addr_q[BLOCK_ADDR_WIDTH-1:IDX_W];

`ifdef MAIN_MEM_CTRL_INIT_PORT_EN
  assign init_active = init_we;
  logic unused_init_addr_hi;
  assign unused_init_addr_hi = ^init_block_addr[BLOCK_ADDR_WIDTH-1:IDX_W];
`else
  assign init_active = 1'b0;
`endif

  // Next-state, readiness and completion strobes
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    req_addr_d       = req_addr_q;
    req_type_d       = req_type_q;
    req_data_d       = req_data_q;
    icache_req_ready = 1'b0;
    dcache_req_ready = 1'b0;
    i_fire           = 1'b0;
    d_fire           = 1'b0;
    mem_we           = 1'b0;
    case (state_q)
      S_IDLE: begin
        icache_req_ready = !icache_flush && !init_active;
        dcache_req_ready = !icache_req_valid && !init_active;
        if (icache_req_valid && !icache_flush && !init_active) begin
          state_d    = S_BUSY_I;
          cnt_d      = CNT_W'(MEM_LATENCY - 1);
          req_addr_d = icache_req_block_addr;
          req_type_d = 1'b0;
          req_data_d = '0;
        end else if (dcache_req_valid && !icache_req_valid && !init_active) begin
          state_d    = S_BUSY_D;
          cnt_d      = CNT_W'(MEM_LATENCY - 1);
          req_addr_d = dcache_req_block_addr;
          req_type_d = dcache_req_type;
          req_data_d = dcache_req_block_data;
        end
      end
      S_BUSY_I: begin
        // A redirect drops the fetch, including on its completion edge.
        if (icache_flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          i_fire  = 1'b1;
        end
      end
      S_BUSY_D: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          d_fire  = 1'b1;
          mem_we  = req_type_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, request and response registers
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      state_q                <= S_IDLE;
      cnt_q                  <= '0;
      req_addr_q             <= '0;
      req_type_q             <= 1'b0;
      req_data_q             <= '0;
      icache_resp_valid      <= 1'b0;
      icache_resp_block_data <= '0;
      dcache_resp_valid      <= 1'b0;
      dcache_resp_block_data <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      req_addr_q        <= req_addr_d;
      req_type_q        <= req_type_d;
      req_data_q        <= req_data_d;
      icache_resp_valid <= i_fire;
      dcache_resp_valid <= d_fire;
      if (i_fire) begin
        icache_resp_block_data <= mem[req_idx];
      end
      if (d_fire) begin
        dcache_resp_block_data <= req_type_q ? req_data_q : mem[req_idx];
      end
    end
  end

  // Array is never reset; the init write is ordered last so it wins on a collision.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[req_idx] <= req_data_q;
    end
`ifdef MAIN_MEM_CTRL_INIT_PORT_EN
    if (init_active) begin
      mem[init_block_addr[IDX_W-1:0]] <= init_block_data;
    end
`endif
  end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl: directed scenarios plus random traffic against a
// transaction-level model that tracks each request by its completion edge number.
module tb_main_mem_ctrl;

  localparam int unsigned BW    = 64;
  localparam int unsigned AW    = 29;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 4;

  logic          clk = 1'b0;
  logic          rst_aH = 1'b1;
  logic          icache_flush = 1'b0;
  logic          icache_req_valid = 1'b0;
  logic [AW-1:0] icache_req_block_addr = '0;
  logic          icache_req_ready;
  logic          icache_resp_valid;
  logic [BW-1:0] icache_resp_block_data;
  logic          dcache_req_valid = 1'b0;
  logic          dcache_req_type = 1'b0;
  logic [AW-1:0] dcache_req_block_addr = '0;
  logic [BW-1:0] dcache_req_block_data = '0;
  logic          dcache_req_ready;
  logic          dcache_resp_valid;
  logic [BW-1:0] dcache_resp_block_data;

  always #5 clk = ~clk;

  main_mem_ctrl #(
    .BLOCK_WIDTH(BW), .BLOCK_ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .MEM_LATENCY(LAT)
  ) dut (
    .clk                    (clk),
    .rst_aH                 (rst_aH),
    .icache_flush           (icache_flush),
    .icache_req_valid       (icache_req_valid),
    .icache_req_block_addr  (icache_req_block_addr),
    .icache_req_ready       (icache_req_ready),
    .icache_resp_valid      (icache_resp_valid),
    .icache_resp_block_data (icache_resp_block_data),
    .dcache_req_valid       (dcache_req_valid),
    .dcache_req_type        (dcache_req_type),
    .dcache_req_block_addr  (dcache_req_block_addr),
    .dcache_req_block_data  (dcache_req_block_data),
    .dcache_req_ready       (dcache_req_ready),
    .dcache_resp_valid      (dcache_resp_valid),
    .dcache_resp_block_data (dcache_resp_block_data)
`ifdef MAIN_MEM_CTRL_INIT_PORT_EN
    ,
    .init_we                (1'b0),
    .init_block_addr        ('0),
    .init_block_data        ('0)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory contents plus the single outstanding transaction.
  logic [BW-1:0] mem_m [DEPTH];
  bit            pend = 1'b0;
  bit            pend_i, pend_wr;
  logic [AW-1:0] pend_addr;
  logic [BW-1:0] pend_data;
  longint        edge_n = 0;
  longint        pend_edge;
  bit            accepted;
  bit            exp_ival = 1'b0, exp_dval = 1'b0;
  logic [BW-1:0] exp_idata = '0, exp_ddata = '0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned idx_of(input logic [AW-1:0] a);
    return int'(a) % DEPTH;
  endfunction

  // Advance the model across one rising edge using the inputs that were driven for it.
  task automatic model_edge();
    edge_n++;
    accepted = 1'b0;
    exp_ival = 1'b0;
    exp_dval = 1'b0;
    if (pend) begin
      if (pend_i && icache_flush) begin
        pend = 1'b0;
      end else if (edge_n == pend_edge) begin
        pend = 1'b0;
        if (pend_i) begin
          exp_ival  = 1'b1;
          exp_idata = mem_m[idx_of(pend_addr)];
        end else begin
          exp_dval = 1'b1;
          if (pend_wr) begin
            mem_m[idx_of(pend_addr)] = pend_data;
            exp_ddata = pend_data;
          end else begin
            exp_ddata = mem_m[idx_of(pend_addr)];
          end
        end
      end
    end else if (icache_req_valid && !icache_flush) begin
      pend = 1'b1; pend_i = 1'b1; pend_wr = 1'b0;
      pend_addr = icache_req_block_addr; pend_edge = edge_n + LAT; accepted = 1'b1;
    end else if (dcache_req_valid && !icache_req_valid) begin
      pend = 1'b1; pend_i = 1'b0; pend_wr = dcache_req_type;
      pend_addr = dcache_req_block_addr; pend_data = dcache_req_block_data;
      pend_edge = edge_n + LAT; accepted = 1'b1;
    end
  endtask

  task automatic cycle(input bit iv, input logic [AW-1:0] ia, input bit fl,
                       input bit dv, input bit dt, input logic [AW-1:0] da,
                       input logic [BW-1:0] dd);
    @(negedge clk);
    icache_req_valid = iv; icache_req_block_addr = ia; icache_flush = fl;
    dcache_req_valid = dv; dcache_req_type = dt;
    dcache_req_block_addr = da; dcache_req_block_data = dd;
    #1;
    check("icache_req_ready", icache_req_ready, !pend && !fl);
    check("dcache_req_ready", dcache_req_ready, !pend && !iv);
    check("icache_resp_valid", icache_resp_valid, exp_ival);
    if (exp_ival) check("icache_resp_data", icache_resp_block_data, exp_idata);
    check("dcache_resp_valid", dcache_resp_valid, exp_dval);
    if (exp_dval) check("dcache_resp_data", dcache_resp_block_data, exp_ddata);
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, '0, 0, 0, 0, '0, '0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (pend && k < 40) begin
      idle(1);
      k++;
    end
    if (pend) check("drain_timeout", 64'd0, 64'd1);
    idle(1);
  endtask

  task automatic req_i(input logic [AW-1:0] a);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      cycle(1, a, 0, 0, 0, '0, '0);
      done = accepted;
    end
    if (!done) check("req_i_timeout", 64'd0, 64'd1);
  endtask

  task automatic req_d(input bit t, input logic [AW-1:0] a, input logic [BW-1:0] d);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      cycle(0, '0, 0, 1, t, a, d);
      done = accepted;
    end
    if (!done) check("req_d_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_aH = 1'b1;
    icache_req_valid = 1'b0; dcache_req_valid = 1'b0; icache_flush = 1'b0;
    pend = 1'b0; exp_ival = 1'b0; exp_dval = 1'b0; exp_idata = '0; exp_ddata = '0;
    #1;
    check("rst_icache_resp_valid", icache_resp_valid, 1'b0);
    check("rst_dcache_resp_valid", dcache_resp_valid, 1'b0);
    check("rst_icache_resp_data", icache_resp_block_data, '0);
    check("rst_dcache_resp_data", dcache_resp_block_data, '0);
    @(negedge clk);
    rst_aH = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom);
    a[9:6] = 4'd0;
    return a;
  endfunction

  initial begin
    do_reset();

    // Preload indices 0..63 through dcache writes.
    for (int i = 0; i < 64; i++) begin
      req_d(1, AW'(i), {$urandom, $urandom});
    end
    drain();
    req_d(1, AW'('h10), 64'hDEADBEEF_00000013);
    drain();

    // Plain icache fill with latency and ready-low window.
    req_i(AW'('h10));
    drain();

    // Simultaneous requests: icache wins, dcache follows when the fill returns.
    cycle(1, AW'('h10), 0, 1, 0, AW'('h11), '0);
    check("both_valid_icache_won", {63'd0, pend_i}, 64'd1);
    req_d(0, AW'('h11), '0);
    drain();

    // Write then icache read of the same block.
    req_d(1, AW'('h20), 64'h1234);
    drain();
    req_i(AW'('h20));
    drain();

    // Flush two cycles after acceptance: no fill, ready right after.
    req_i(AW'('h10));
    idle(1);
    cycle(0, '0, 1, 0, 0, '0, '0);
    drain();

    // Flush on the completion edge suppresses the response.
    req_i(AW'('h12));
    idle(LAT - 1);
    cycle(0, '0, 1, 0, 0, '0, '0);
    drain();

    // Reset mid-write leaves the old contents in place.
    req_d(1, AW'('h30), 64'hAA);
    drain();
    req_d(1, AW'('h30), 64'h55);
    idle(2);
    do_reset();
    req_d(0, AW'('h30), '0);
    drain();

    // Aliasing of upper address bits.
    req_i(AW'('h410));
    drain();

    // Random mixed traffic.
    for (int n = 0; n < 500; n++) begin
      cycle($urandom_range(0, 2) == 0, rand_addr(), $urandom_range(0, 11) == 0,
            $urandom_range(0, 1) == 0, 1'($urandom), rand_addr(), {$urandom, $urandom});
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
